// File: rtl/primo_seq.sv
// primo_seq: sequential primality tester using odd trial division, one divisor per clock.
// An operand is accepted on start in IDLE. Even numbers and 0..3 are decided in a single
// FILTER cycle. Other operands go to TEST, which tries d = 3, 5, 7, ... until d*d > n
// or d divides n.
// Optional feature: define PRIMO_FACTOR_EN to add the factor port (smallest divisor found).
// Ports:
//   clk, rst_n  - clock (rising edge), asynchronous active-low reset
//   start       - request pulse, sampled only in IDLE
//   n           - WIDTH-bit unsigned operand, latched on accepted start
//   busy        - high while in FILTER or TEST
//   done        - one-cycle pulse in DONE
//   is_prime    - result, valid from done until the next accepted start
//   factor      - smallest divisor found, 0 for primes, 0 and 1 (PRIMO_FACTOR_EN only)
module primo_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             is_prime
`ifdef PRIMO_FACTOR_EN
    ,
    output logic [WIDTH-1:0] factor
`endif
);

    localparam int unsigned SQ_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILTER = 2'd1,
        S_TEST   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] n_q, n_q_nxt;
    logic [WIDTH-1:0] d, d_nxt;
    logic             is_prime_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic [SQ_W-1:0]  sq;
    logic             divides;
`ifdef PRIMO_FACTOR_EN
    logic [WIDTH-1:0] factor_nxt;
`endif

    // Full-width square, so the loop bound never overflows.
    assign sq = SQ_W'(d) * SQ_W'(d);
    // d is at least 3 whenever this is used; the guard only keeps IDLE free of divide-by-zero.
    assign divides = (d != '0) && ((n_q % d) == '0);

    // Next-state and next-register values.
    always_comb begin
        state_nxt    = state;
        n_q_nxt      = n_q;
        d_nxt        = d;
        is_prime_nxt = is_prime;
`ifdef PRIMO_FACTOR_EN
        factor_nxt   = factor;
`endif
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    n_q_nxt      = n;
                    is_prime_nxt = 1'b0;
`ifdef PRIMO_FACTOR_EN
                    factor_nxt   = '0;
`endif
                    state_nxt    = S_FILTER;
                end
            end
            S_FILTER: begin
                if (n_q <= WIDTH'(1)) begin
                    is_prime_nxt = 1'b0;
                    state_nxt    = S_DONE;
                end else if ((n_q == WIDTH'(2)) || (n_q == WIDTH'(3))) begin
                    is_prime_nxt = 1'b1;
                    state_nxt    = S_DONE;
                end else if (!n_q[0]) begin
                    is_prime_nxt = 1'b0;
`ifdef PRIMO_FACTOR_EN
                    factor_nxt   = WIDTH'(2);
`endif
                    state_nxt    = S_DONE;
                end else begin
                    d_nxt        = WIDTH'(3);
                    state_nxt    = S_TEST;
                end
            end
            S_TEST: begin
                if (sq > SQ_W'(n_q)) begin
                    is_prime_nxt = 1'b1;
                    state_nxt    = S_DONE;
                end else if (divides) begin
                    is_prime_nxt = 1'b0;
`ifdef PRIMO_FACTOR_EN
                    factor_nxt   = d;
`endif
                    state_nxt    = S_DONE;
                end else begin
                    d_nxt        = d + WIDTH'(2);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        busy_nxt = (state_nxt == S_FILTER) || (state_nxt == S_TEST);
        done_nxt = (state_nxt == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            n_q      <= '0;
            d        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            is_prime <= 1'b0;
`ifdef PRIMO_FACTOR_EN
            factor   <= '0;
`endif
        end else begin
            state    <= state_nxt;
            n_q      <= n_q_nxt;
            d        <= d_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            is_prime <= is_prime_nxt;
`ifdef PRIMO_FACTOR_EN
            factor   <= factor_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_primo_seq.sv
// Self-checking bench for primo_seq. It drives a WIDTH=8 and a WIDTH=4 instance and
// compares each one against a reference model built from plain arithmetic.
module tb_primo_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_drv;
    logic [7:0] n_drv;
    logic       use4;

    logic       start8, start4;
    logic [7:0] n8;
    logic [3:0] n4;
    logic       busy8, done8, prime8;
    logic       busy4, done4, prime4;
    logic       o_busy, o_done, o_prime;
`ifdef PRIMO_FACTOR_EN
    logic [7:0] factor8;
    logic [3:0] factor4;
    logic [7:0] o_factor;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign start8  = start_drv & ~use4;
    assign start4  = start_drv & use4;
    assign n8      = n_drv;
    assign n4      = n_drv[3:0];
    assign o_busy  = use4 ? busy4  : busy8;
    assign o_done  = use4 ? done4  : done8;
    assign o_prime = use4 ? prime4 : prime8;
`ifdef PRIMO_FACTOR_EN
    assign o_factor = use4 ? {4'b0, factor4} : factor8;
`endif

    primo_seq #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start8),
        .n        (n8),
        .busy     (busy8),
        .done     (done8),
        .is_prime (prime8)
`ifdef PRIMO_FACTOR_EN
        ,
        .factor   (factor8)
`endif
    );

    primo_seq #(.WIDTH(4)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start4),
        .n        (n4),
        .busy     (busy4),
        .done     (done4),
        .is_prime (prime4)
`ifdef PRIMO_FACTOR_EN
        ,
        .factor   (factor4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Smallest divisor >= 2, or 0 for 0, 1 and primes.
    function automatic int ref_factor(input int v);
        if (v < 2) return 0;
        for (int i = 2; i < v; i++) if (v % i == 0) return i;
        return 0;
    endfunction

    function automatic int ref_prime(input int v);
        return (v >= 2 && ref_factor(v) == 0) ? 1 : 0;
    endfunction

    // Edges from acceptance to done. The loop tries odd d from 3 upward, one per edge.
    // A composite stops at its smallest factor f after (f-1)/2 tries. A prime tries every
    // odd d in 3..isqrt(v), then one more to see d*d > v.
    function automatic int ref_latency(input int v);
        int s;
        if (v <= 3 || v % 2 == 0) return 1;
        if (ref_prime(v) == 0) return 1 + (ref_factor(v) - 1) / 2;
        s = 0;
        while ((s + 1) * (s + 1) <= v) s++;
        return 2 + ((s >= 3) ? (s - 1) / 2 : 0);
    endfunction

    // Start one operation and check timing and result. With noise set, n and start
    // are randomised while the operation is in flight.
    task automatic run_op(input int v, input bit noise);
        int lat;
        bit got;
        n_drv     = 8'(v);
        start_drv = 1'b1;
        @(posedge clk); #1;
        start_drv = 1'b0;
        check("busy_after_accept", 32'(o_busy), 1);
        check("done_after_accept", 32'(o_done), 0);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 300) begin
            if (noise) begin
                start_drv = 1'($urandom_range(0, 1));
                n_drv     = 8'($urandom);
            end
            @(posedge clk); #1;
            lat++;
            check("busy_done_exclusive", 32'(o_busy & o_done), 0);
            got = o_done;
        end
        start_drv = 1'b0;
        check("done_seen", 32'(got), 1);
        check($sformatf("latency_n%0d", v), 32'(lat), 32'(ref_latency(v)));
        check($sformatf("is_prime_n%0d", v), 32'(o_prime), 32'(ref_prime(v)));
`ifdef PRIMO_FACTOR_EN
        check($sformatf("factor_n%0d", v), 32'(o_factor), 32'(ref_factor(v)));
`endif
        @(posedge clk); #1;
        check("done_one_cycle", 32'(o_done), 0);
        check("idle_not_busy", 32'(o_busy), 0);
        check($sformatf("held_n%0d", v), 32'(o_prime), 32'(ref_prime(v)));
    endtask

    initial begin
        int done_edge;
        rst_n     = 1'b0;
        start_drv = 1'b0;
        n_drv     = '0;
        use4      = 1'b0;
        #12;
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_prime", 32'(o_prime), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("idle_busy", 32'(o_busy), 0);
            check("idle_done", 32'(o_done), 0);
            check("idle_prime", 32'(o_prime), 0);
`ifdef PRIMO_FACTOR_EN
            check("idle_factor", 32'(o_factor), 0);
`endif
        end

        // Directed operands: filtered and iterated.
        run_op(0, 1'b0);
        run_op(1, 1'b0);
        run_op(2, 1'b0);
        run_op(4, 1'b0);
        run_op(7, 1'b0);
        run_op(9, 1'b0);
        run_op(25, 1'b0);
        run_op(251, 1'b0);

        // Handshake: starts with n=4 at edges 3 and 9 must be ignored.
        n_drv     = 8'd251;
        start_drv = 1'b1;
        @(posedge clk); #1;
        start_drv = 1'b0;
        done_edge = -1;
        for (int e = 1; e <= 12; e++) begin
            if (e == 3 || e == 9) begin
                start_drv = 1'b1;
                n_drv     = 8'd4;
            end
            @(posedge clk); #1;
            start_drv = 1'b0;
            if (o_done && done_edge < 0) done_edge = e;
        end
        check("hs_done_edge", 32'(done_edge), 9);
        check("hs_prime_kept", 32'(o_prime), 1);
        check("hs_idle", 32'(o_busy), 0);
        run_op(4, 1'b0);

        // Reset mid-operation.
        n_drv     = 8'd251;
        start_drv = 1'b1;
        @(posedge clk); #1;
        start_drv = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy_before_rst", 32'(o_busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(o_busy), 0);
        check("mid_rst_done", 32'(o_done), 0);
        check("mid_rst_prime", 32'(o_prime), 0);
`ifdef PRIMO_FACTOR_EN
        check("mid_rst_factor", 32'(o_factor), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(15, 1'b0);

        // Exhaustive sweeps with bus noise while busy.
        use4 = 1'b1;
        for (int v = 0; v < 16; v++) run_op(v, 1'b1);
        use4 = 1'b0;
        for (int v = 0; v < 256; v++) run_op(v, 1'b1);

        // Random operands with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run_op(int'($urandom_range(0, 255)), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
